mac_layer: RTL

Parametrised, time-multiplexed fully-connected MAC layer for the GNN datapath. It accepts a vector of N_IN signed node features plus an N_IN×N_OUT signed weight matrix over a valid/ready handshake. It accumulates one input term per cycle into N_OUT parallel lanes, then presents N_OUT saturated neuron outputs with their own valid/ready handshake. It replaces the fixed 4×4 single-cycle MAC stage and trades latency for N_OUT multipliers instead of N_IN×N_OUT.

---
 rtl/mac_pkg.sv | 55 +++++
 rtl/mac_lane.sv | 87 ++++++++
 rtl/mac_layer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
//------------------------------------------------------------------------------
// mac_pkg
//   Shared types and helpers for the time-multiplexed MAC layer:
//   FSM state enum, saturation helper, and the accumulator width helper.
//   Optional feature macro used by the design: MAC_RELU_EN.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation works on a 64-bit sign-extended value so that one function
  // serves any accumulator/output width pair (both must be below 64).
  typedef struct packed {
    logic signed [63:0] value;
    logic               clamped;
  } sat_t;

  // Accumulator width that can hold N_IN full-precision products.
  function automatic int acc_width(input int xw, input int ww, input int n_in);
    return xw + ww + $clog2(n_in);
  endfunction

  // Clamp an in_w-bit signed value into out_w bits. With out_w >= in_w the
  // value always fits, so no clamp is ever reported.
  function automatic sat_t saturate(input logic signed [63:0] v,
                                    input int in_w, input int out_w);
    sat_t r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r.value   = v;
    r.clamped = 1'b0;
    if (out_w < in_w) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
        r.value   = hi;
        r.clamped = 1'b1;
      end else if (v < lo) begin
        r.value   = lo;
        r.clamped = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_lane.sv
//------------------------------------------------------------------------------
// mac_lane
//   One output neuron lane: signed multiplier, ACCW-bit accumulator with
//   clear/enable, and a saturating (optionally ReLU) output register.
//   Optional feature macro: MAC_RELU_EN (ReLU after saturation).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     clear       zero the accumulator (new operation accepted)
//     en          accumulate x*w this cycle
//     last        this is the final term; load y/sat from acc + product
//     x, w        signed feature and weight for the current term
//     y, sat      registered saturated result and clamp flag
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_lane
  import mac_pkg::*;
#(
  parameter int XW   = 7,
  parameter int WW   = 5,
  parameter int OW   = 13,
  parameter int ACCW = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 last,
  input  logic signed [XW-1:0] x,
  input  logic signed [WW-1:0] w,
  output logic signed [OW-1:0] y,
  output logic                 sat
);

  localparam int PW = XW + WW;

  logic signed [PW-1:0]   x_ext;
  logic signed [PW-1:0]   w_ext;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;
  logic signed [63:0]     sum_ext;
  sat_t                   sres;
  logic signed [OW-1:0]   y_next;
  logic                   unused_hi_bits;

  // Operands are widened to the full product width first so the multiply is
  // exact and self-determined at PW bits.
  assign x_ext   = {{WW{x[XW-1]}}, x};
  assign w_ext   = {{XW{w[WW-1]}}, w};
  assign prod    = x_ext * w_ext;
  assign sum     = acc + {{(ACCW-PW){prod[PW-1]}}, prod};
  assign sum_ext = {{(64-ACCW){sum[ACCW-1]}}, sum};
  assign sres    = saturate(sum_ext, ACCW, OW);

  // Bits above OW are redundant sign copies after saturation.
  assign unused_hi_bits = ^sres.value[63:OW];

  always_comb begin
    y_next = sres.value[OW-1:0];
`ifdef MAC_RELU_EN
    if (y_next[OW-1]) begin
      y_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      y   <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
      if (last) begin
        y   <= y_next;
        sat <= sres.clamped;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_layer.sv
//------------------------------------------------------------------------------
// mac_layer
//   Time-multiplexed fully-connected MAC layer: one input term per cycle is
//   accumulated into N_OUT parallel lanes; results are N_OUT saturated
//   outputs presented over a valid/ready handshake.
//   Optional feature macro: MAC_RELU_EN (ReLU on outputs, inside mac_lane).
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//     x_flat               feature i at [i*XW +: XW]
//     w_flat               weight i->j at [(j*N_IN+i)*WW +: WW]
//     out_valid/out_ready  result handshake (out_valid high only in DONE)
//     y_flat               neuron j at [j*OW +: OW]
//     sat                  lane j clamped on this result
//     busy                 operation in progress (state != IDLE)
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_layer
  import mac_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int XW    = 7,
  parameter int WW    = 5,
  parameter int OW    = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*XW-1:0]       x_flat,
  input  logic [N_IN*N_OUT*WW-1:0] w_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*OW-1:0]      y_flat,
  output logic [N_OUT-1:0]         sat,
  output logic                     busy
);

  localparam int ACCW = acc_width(XW, WW, N_IN);
  localparam int KW   = $clog2(N_IN);

  state_t                    state;
  state_t                    state_next;
  logic [KW-1:0]             k;
  logic [N_IN*XW-1:0]        x_reg;
  logic [N_IN*N_OUT*WW-1:0]  w_reg;
  logic [XW-1:0]             x_cur;
  logic                      accept;
  logic                      last;
  logic                      acc_en;

  assign accept = (state == IDLE) && in_valid;
  assign acc_en = (state == ACC);
  assign last   = (k == KW'(N_IN - 1));
  assign x_cur  = x_reg[k*XW +: XW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ACC;
        end
      end
      ACC: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      x_reg <= '0;
      w_reg <= '0;
    end else if (accept) begin
      k     <= '0;
      x_reg <= x_flat;
      w_reg <= w_flat;
    end else if (acc_en) begin
      k <= last ? '0 : k + KW'(1);
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    logic [WW-1:0] w_cur;
    assign w_cur = w_reg[(j*N_IN + int'(k))*WW +: WW];

    mac_lane #(
      .XW   (XW),
      .WW   (WW),
      .OW   (OW),
      .ACCW (ACCW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .en    (acc_en),
      .last  (last),
      .x     (x_cur),
      .w     (w_cur),
      .y     (y_flat[j*OW +: OW]),
      .sat   (sat[j])
    );
  end

endmodule

`default_nettype wire
